pipeline_hazard_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/hazard_scoreboard.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 56 +++++
 tb/tb_pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-32 opcodes, register constants, scoreboard tag and controller state types
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic       valid;
    logic [4:0] rnum;
  } tag_t;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tag chain, ID source compare and busy register mask
module hazard_scoreboard import mips_pkg::*; #(
  parameter int HAZ_DEPTH = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_reg,
  input  logic        check_en,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        uses_rs,
  input  logic        uses_rt,
  output logic        hazard,
  output logic [31:0] busy_mask
);
  tag_t [HAZ_DEPTH-1:0] tags;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tags <= '0;
    else begin
      tags[0] <= '{valid: push, rnum: push_reg};
      for (int i = 1; i < HAZ_DEPTH; i++) tags[i] <= tags[i-1];
    end
  always_comb begin
    hazard = 1'b0;
    busy_mask = '0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (tags[i].valid) busy_mask[tags[i].rnum] = 1'b1;
    for (int i = 0; i < HAZ_DEPTH - WB_BYPASS; i++)
      hazard = hazard | (check_en && tags[i].valid && tags[i].rnum != REG_ZERO &&
               ((uses_rs && rs == tags[i].rnum) || (uses_rt && rt == tags[i].rnum)));
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, EX bubble and jump flush sequencing for the non-forwarding 5-stage pipeline
module pipeline_hazard_ctrl import mips_pkg::*; #(
  parameter int HAZ_DEPTH    = 3,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_writes,
  input  logic             id_is_jump,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             jump_cs,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [31:0]      busy_mask
);
  state_t     state;
  logic [1:0] flush_cnt;
  logic       run, live, hazard, issue, push;
  assign run = state == RUN;
  assign live = rst_n && id_valid && run;
  assign stall = hazard;
  assign issue = live && !hazard;
  assign jump_cs = issue && id_is_jump;
  assign flush_if_id = jump_cs || !run;
  assign bubble_ex = rst_n && (stall || !run || !id_valid);
  assign push = issue && id_writes && id_dest != REG_ZERO;
  hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH), .WB_BYPASS(WB_BYPASS)) u_sb (
    .clk(clk), .rst_n(rst_n), .push(push), .push_reg(id_dest), .check_en(live),
    .rs(id_rs), .rt(id_rt), .uses_rs(id_uses_rs), .uses_rt(id_uses_rt),
    .hazard(hazard), .busy_mask(busy_mask)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (jump_cs && FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        flush_cnt <= 2'(FLUSH_CYCLES - 1);
      end else if (!run) begin
        flush_cnt <= flush_cnt - 1'b1;
        if (flush_cnt == 2'd1) state <= RUN;
      end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of two controller variants against an in-flight register model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_writes = 0, id_is_jump = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;
  logic stall [2], bubble [2], flush [2], jump [2];
  logic [31:0] busy [2];
  logic [15:0] cnt0;
  logic [3:0] cnt1;
  int checks = 0, errors = 0;
  int pipe [2][3];
  int fl [2];
  int scnt [2];
  int fc [2] = '{1, 3};
  int smax [2] = '{65535, 15};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl u_d0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_writes(id_writes),
    .id_is_jump(id_is_jump), .stall(stall[0]), .bubble_ex(bubble[0]), .flush_if_id(flush[0]),
    .jump_cs(jump[0]), .stall_cnt(cnt0), .busy_mask(busy[0])
  );
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_writes(id_writes),
    .id_is_jump(id_is_jump), .stall(stall[1]), .bubble_ex(bubble[1]), .flush_if_id(flush[1]),
    .jump_cs(jump[1]), .stall_cnt(cnt1), .busy_mask(busy[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pipe[d] = '{0, 0, 0};
      fl[d] = 0;
      scnt[d] = 0;
    end
  endtask
  task automatic check_zero(input string t);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_stall%0d", t, d), stall[d], 0);
      check($sformatf("%s_bubble%0d", t, d), bubble[d], 0);
      check($sformatf("%s_flush%0d", t, d), flush[d], 0);
      check($sformatf("%s_jump%0d", t, d), jump[d], 0);
      check($sformatf("%s_busy%0d", t, d), busy[d], 0);
    end
    check({t, "_cnt0"}, cnt0, 0);
    check({t, "_cnt1"}, cnt1, 0);
  endtask
  task automatic cycle(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                       input int dest, input logic wr, input logic j);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dest); id_writes = wr; id_is_jump = j;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic run, live, haz, jmp;
      logic [31:0] bm;
      run = fl[d] == 0;
      live = run && v;
      haz = 0;
      for (int i = 0; i < 2; i++)
        if (pipe[d][i] != 0 && ((urs && rs == pipe[d][i]) || (urt && rt == pipe[d][i]))) haz = live;
      jmp = live && !haz && j;
      bm = 0;
      for (int i = 0; i < 3; i++) if (pipe[d][i] != 0) bm[pipe[d][i]] = 1'b1;
      check($sformatf("stall%0d", d), stall[d], haz);
      check($sformatf("jump%0d", d), jump[d], jmp);
      check($sformatf("flush%0d", d), flush[d], jmp || !run);
      check($sformatf("bubble%0d", d), bubble[d], haz || !run || !v);
      check($sformatf("busy%0d", d), busy[d], bm);
      check($sformatf("cnt%0d", d), d == 0 ? 32'(cnt0) : 32'(cnt1), scnt[d]);
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = pipe[d][0];
      pipe[d][0] = (live && !haz && wr) ? dest : 0;
      if (jmp) fl[d] = fc[d] - 1;
      else if (!run) fl[d]--;
      if (haz && scnt[d] < smax[d]) scnt[d]++;
    end
  endtask
  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    cycle(1, 1, 2, 1, 1, 3, 1, 0);
    cycle(1, 3, 4, 1, 0, 8, 1, 0);
    check("t1_stall_a", stall[0], 1);
    check("t1_bubble_a", bubble[0], 1);
    cycle(1, 3, 4, 1, 0, 8, 1, 0);
    check("t1_stall_b", stall[0], 1);
    check("t1_bubble_b", bubble[0], 1);
    cycle(1, 3, 4, 1, 0, 8, 1, 0);
    check("t1_issue", stall[0], 0);
    check("t1_cnt", cnt0, 2);
    repeat (3) nop();
    cycle(1, 1, 2, 1, 1, 4, 1, 0);
    cycle(1, 1, 2, 1, 1, 9, 1, 0);
    cycle(1, 0, 4, 0, 1, 10, 1, 0);
    check("t2_stall", stall[0], 1);
    cycle(1, 0, 4, 0, 1, 10, 1, 0);
    check("t2_release", stall[0], 0);
    repeat (3) nop();
    cycle(1, 1, 2, 1, 1, 5, 1, 0);
    nop();
    nop();
    cycle(1, 5, 0, 1, 0, 0, 0, 0);
    check("t2_wb_bypass", stall[0], 0);
    repeat (3) nop();
    cycle(1, 1, 2, 1, 1, 0, 1, 0);
    cycle(1, 0, 0, 1, 1, 0, 0, 0);
    check("t3_stall", stall[0], 0);
    check("t3_busy", busy[0], 0);
    repeat (3) nop();
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check("t4_jump", jump[0], 1);
    check("t4_flush", flush[0], 1);
    check("t4_flush3_a", flush[1], 1);
    cycle(1, 1, 2, 1, 1, 7, 1, 0);
    check("t4_nojump", jump[0], 0);
    check("t4_noflush", flush[0], 0);
    check("t4_issue", bubble[0], 0);
    check("t4_flush3_b", flush[1], 1);
    check("t4_ignored", bubble[1], 1);
    nop();
    check("t4_flush3_c", flush[1], 1);
    nop();
    check("t4_flush3_end", flush[1], 0);
    check("t4_dropped", busy[1], 0);
    repeat (3) nop();
    cycle(1, 1, 2, 1, 1, 5, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 5, 0, 1, 0, 0, 0, 1);
      check($sformatf("t5_stall%0d", k), stall[0], k < 2);
      check($sformatf("t5_jump%0d", k), jump[0], k == 2);
    end
    repeat (4) nop();
    cycle(1, 1, 2, 1, 1, 6, 1, 0);
    cycle(1, 6, 0, 1, 0, 0, 0, 0);
    check("t6_in_stall", stall[0], 1);
    #1 rst_n = 1'b0;
    #1 check_zero("rst_stall");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    nop();
    check("t6_in_flush", flush[1], 1);
    #1 rst_n = 1'b0;
    #1 check_zero("rst_flush");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 2, 3, 1, 1, 1, 1, 0);
      repeat (3) cycle(1, 1, 0, 1, 0, 0, 0, 0);
    end
    check("sat_cnt1", cnt1, 15);
    check("sat_cnt0", cnt0, 16);
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
